db_fsm: RTL and testbench

DB_FSM -- requirements
Module: db_fsm

---
 rtl/db_fsm_pkg.sv | 17 +
 rtl/db_tick_gen.sv | 24 ++
 rtl/db_fsm.sv | 66 ++++++
 tb/tb_db_fsm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/db_fsm_pkg.sv
// rtl/db_fsm_pkg.sv - shared state encoding and tick-width default for the debouncer
package db_fsm_pkg;

  localparam int N_DEFAULT = 19;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } state_e;

endpackage

// File: rtl/db_tick_gen.sv
// rtl/db_tick_gen.sv - free-running N-bit counter emitting a sample tick at zero
module db_tick_gen #(
  parameter int N = 19
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic m_tick_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  assign cnt_d    = cnt_q + N'(1);
  assign m_tick_o = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/db_fsm.sv
// rtl/db_fsm.sv - switch debouncer: synchronizer, 3-tick stability FSM, press pulse
module db_fsm
  import db_fsm_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  logic   sw_meta_q;
  logic   sw_s_q;
  logic   m_tick;
  state_e state_q;
  state_e state_d;
  logic   db_tick_q;
  logic   db_tick_d;

  db_tick_gen #(.N(N)) u_tick_gen (
    .clk_i    (clk),
    .reset_i  (reset),
    .m_tick_o (m_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
      state_q   <= ZERO;
      db_tick_q <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
      state_q   <= state_d;
      db_tick_q <= db_tick_d;
    end
  end

  // A level mismatch always wins over a coincident tick, so bounces restart the wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    if (sw_s_q) state_d = WAIT1_1;
      WAIT1_1: if (!sw_s_q) state_d = ZERO; else if (m_tick) state_d = WAIT1_2;
      WAIT1_2: if (!sw_s_q) state_d = ZERO; else if (m_tick) state_d = WAIT1_3;
      WAIT1_3: if (!sw_s_q) state_d = ZERO; else if (m_tick) state_d = ONE;
      ONE:     if (!sw_s_q) state_d = WAIT0_1;
      WAIT0_1: if (sw_s_q) state_d = ONE; else if (m_tick) state_d = WAIT0_2;
      WAIT0_2: if (sw_s_q) state_d = ONE; else if (m_tick) state_d = WAIT0_3;
      WAIT0_3: if (sw_s_q) state_d = ONE; else if (m_tick) state_d = ZERO;
      default: state_d = ZERO;
    endcase
  end

  always_comb begin
    db_tick_d = (state_q == WAIT1_3) && (state_d == ONE);
    db_level  = (state_q == ONE)     || (state_q == WAIT0_1) ||
                (state_q == WAIT0_2) || (state_q == WAIT0_3);
  end

  assign db_tick = db_tick_q;

endmodule

// File: tb/tb_db_fsm.sv
// tb/tb_db_fsm.sv - randomized and directed checks of db_fsm against a behavioural model
module tb_db_fsm;
  import db_fsm_pkg::*;

  localparam int N = 4;
  localparam int P = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw = 1'b1;
  logic db_level;
  logic db_tick;

  db_fsm #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int tick_hi  = 0;

  // Model: level plus the number of ticks seen while the synchronized input disagrees.
  int m_cnt;
  bit m_s1, m_s2;
  bit m_level, m_pulse;
  int m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
    end
  endtask

  initial begin
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_pend = -1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cnt = 0; m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_pend = -1;
      end else begin
        m_pulse = 0;
        if (m_s2 == m_level) begin
          m_pend = -1;
        end else if (m_pend < 0) begin
          m_pend = 0;
        end else if (m_cnt == 0) begin
          m_pend++;
          if (m_pend == 3) begin
            m_level = !m_level;
            m_pulse = m_level;
            m_pend  = -1;
          end
        end
        m_s2  = m_s1;
        m_s1  = sw;
        m_cnt = (m_cnt + 1) % P;
      end
    end
  end

  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      check("db_level_vs_model", db_level, m_level);
      check("db_tick_vs_model", db_tick, m_pulse);
      if (db_tick === 1'b1) tick_hi++;
      if (db_tick === 1'b1 && !prev) pulses++;
      prev = (db_tick === 1'b1);
    end
  end

  task automatic measure(input bit target, output int lat);
    lat = 0;
    while (db_level !== target && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, p0, h0, waited;

    // Reset held with the switch asserted
    repeat (3) @(negedge clk);
    check("reset_level", db_level, 0);
    check("reset_tick", db_tick, 0);
    check("reset_state", 32'(dut.state_q), 32'(ZERO));
    sw = 0;
    reset = 0;
    repeat (40) @(negedge clk);

    // Short glitches never qualify
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      sw = 1; repeat (5) @(negedge clk);
      sw = 0; repeat (5) @(negedge clk);
    end
    check("glitch_level", db_level, 0);
    check("glitch_pulses", pulses - p0, 0);
    check("glitch_model_pin", m_level, 0);
    repeat (20) @(negedge clk);

    // Clean press
    p0 = pulses; h0 = tick_hi;
    sw = 1;
    measure(1, lat);
    check_range("press_latency", lat, 33, 50);
    check("tick_at_entry", db_tick, 1);
    repeat (64) @(negedge clk);
    check("press_pulses", pulses - p0, 1);
    check("press_pulse_width", tick_hi - h0, 1);
    check("press_model_pin", m_level, 1);

    // Clean release, no pulse
    p0 = pulses;
    sw = 0;
    measure(0, lat);
    check_range("release_latency", lat, 33, 50);
    repeat (64) @(negedge clk);
    check("release_pulses", pulses - p0, 0);
    check("release_model_pin", m_level, 0);

    // Reset in the middle of a press wait
    sw = 1;
    waited = 0;
    while (32'(dut.state_q) != 32'(WAIT1_2) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_range("reach_wait1_2", waited, 0, 199);
    #2 reset = 1;
    #1;
    check("midwait_reset_level", db_level, 0);
    check("midwait_reset_state", 32'(dut.state_q), 32'(ZERO));
    @(negedge clk);
    reset = 0;
    measure(1, lat);
    check_range("post_reset_latency", lat, 33, 50);
    sw = 0;
    repeat (80) @(negedge clk);

    // Three press/release cycles
    p0 = pulses; h0 = tick_hi;
    for (int i = 0; i < 3; i++) begin
      sw = 1; repeat (70) @(negedge clk);
      sw = 0; repeat (70) @(negedge clk);
    end
    check("three_cycles_pulses", pulses - p0, 3);
    check("three_cycles_width", tick_hi - h0, 3);

    // Random bouncing with occasional asynchronous resets
    for (int i = 0; i < 80; i++) begin
      sw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 8)) reset = 1;
        @(negedge clk);
        reset = 0;
      end
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
